// File: rtl/popcount_pkg.sv
// Shared types and helpers for the byte-serial popcount sequencer.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bits needed to hold a count of 0..8*nbytes.
    function automatic int unsigned cnt_width(input int unsigned nbytes);
        return $clog2(8 * nbytes + 1);
    endfunction

endpackage

// File: rtl/popcount8.sv
// Combinational 8-bit population count built as a balanced adder tree.
module popcount8 (
    input  logic [7:0] i_data,
    output logic [3:0] o_count
);

    logic [1:0] w_s2 [4];
    logic [2:0] w_s4 [2];

    for (genvar i = 0; i < 4; i++) begin : g_pair
        assign w_s2[i] = {1'b0, i_data[2*i]} + {1'b0, i_data[2*i+1]};
    end

    for (genvar j = 0; j < 2; j++) begin : g_quad
        assign w_s4[j] = {1'b0, w_s2[2*j]} + {1'b0, w_s2[2*j+1]};
    end

    assign o_count = {1'b0, w_s4[0]} + {1'b0, w_s4[1]};

endmodule

// File: rtl/popcount_sequencer.sv
// Counts set bits of an NBYTES-wide word one byte per cycle through a single popcount8.
// Optional threshold compare enabled by macro POPCOUNT_SEQUENCER_THRESH_EN.
module popcount_sequencer
    import popcount_pkg::*;
#(
    parameter  int unsigned NBYTES = 4,
    localparam int unsigned CW     = cnt_width(NBYTES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*NBYTES-1:0] x,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CW-1:0]       y,
    output logic                out_valid,
`ifdef POPCOUNT_SEQUENCER_THRESH_EN
    input  logic [CW-1:0]       thresh,
    output logic                over,
`endif
    input  logic                out_ready
);

    state_e              r_state;
    logic [8*NBYTES-1:0] r_shreg;
    logic [CW-1:0]       r_acc;
    logic [CW-1:0]       r_idx;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [3:0]          w_pc;

    popcount8 u_popcount8 (
        .i_data  (r_shreg[7:0]),
        .o_count (w_pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_shreg    <= x;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= COUNT;
                    end
                end
                COUNT: begin
                    r_acc   <= r_acc + CW'(w_pc);
                    r_shreg <= r_shreg >> 8;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == CW'(NBYTES - 1)) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Release to IDLE only; a new word is taken on the following cycle.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign y         = r_acc;

`ifdef POPCOUNT_SEQUENCER_THRESH_EN
    logic [CW-1:0] r_thresh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thresh <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_thresh <= thresh;
        end
    end

    assign over = r_out_valid && (r_acc >= r_thresh);
`endif

endmodule

// File: tb/tb_popcount_sequencer.sv
// Directed self-checking bench for popcount_sequencer (NBYTES=4).
module tb_popcount_sequencer;

    localparam int unsigned NBYTES = 4;
    localparam int unsigned CW     = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [8*NBYTES-1:0] x = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [CW-1:0]       y;
    logic                out_valid;
    logic                out_ready = 1'b0;
`ifdef POPCOUNT_SEQUENCER_THRESH_EN
    logic [CW-1:0]       thresh = '0;
    logic                over;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    popcount_sequencer #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
`ifdef POPCOUNT_SEQUENCER_THRESH_EN
        .thresh    (thresh),
        .over      (over),
`endif
        .out_ready (out_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one word, optionally scramble x during COUNT, then check latency and count.
    task automatic run_word(input string tag, input logic [31:0] wx, input bit scramble,
                            input logic [31:0] exp_y);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
        x        = wx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (scramble) x = 32'hFFFF_FFFF;
        check_eq({tag, "_busy"}, 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_lat"}, 32'(n), 32'(NBYTES));
        check_eq({tag, "_y"}, 32'(y), exp_y);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen;
        int t_first;
        int t_second;

        #12;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Idle without in_valid stays put.
        tick();
        check_eq("idle_hold_rdy", 32'(in_ready), 32'd1);

        run_word("zero", 32'h0000_0000, 1'b0, 32'd0);
        release_out("zero");
        run_word("ones", 32'hFFFF_FFFF, 1'b0, 32'd32);
        release_out("ones");
        run_word("mix", 32'hA5A5_0F01, 1'b1, 32'd13);
        release_out("mix");

        // Backpressure: hold in DONE while in_valid is waved around.
        run_word("hold", 32'h0000_0003, 1'b0, 32'd2);
        x        = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("hold_y", 32'(y), 32'd2);
            check_eq("hold_ov", 32'(out_valid), 32'd1);
            check_eq("hold_rdy", 32'(in_ready), 32'd0);
        end
        // Release with in_valid still high: must not accept in the DONE cycle.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("nosame_rdy", 32'(in_ready), 32'd1);
        check_eq("nosame_ov", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check_eq("nosame_idle", 32'(in_ready), 32'd1);

        // Reset during the second COUNT cycle discards the word.
        x        = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_rdy", 32'(in_ready), 32'd1);
        check_eq("arst_y", 32'(y), 32'd0);
        check_eq("arst_ov", 32'(out_valid), 32'd0);
        #3;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check_eq("arst_no_ov", 32'(seen), 32'd0);

        // Streaming with out_ready tied high: one result every NBYTES+2 cycles.
        x         = 32'h0101_0101;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t_first   = -1;
        t_second  = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) begin
                if (t_first < 0) t_first = i;
                else if (t_second < 0) t_second = i;
                check_eq("stream_y", 32'(y), 32'd4);
            end
        end
        check_eq("stream_period", 32'(t_second - t_first), 32'(NBYTES + 2));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (8) tick();

`ifdef POPCOUNT_SEQUENCER_THRESH_EN
        thresh = 6'd13;
        run_word("th13", 32'hA5A5_0F01, 1'b0, 32'd13);
        thresh = 6'd0;
        check_eq("th13_over", 32'(over), 32'd1);
        release_out("th13");
        check_eq("th_over_idle", 32'(over), 32'd0);
        thresh = 6'd14;
        run_word("th14", 32'hA5A5_0F01, 1'b0, 32'd13);
        check_eq("th14_over", 32'(over), 32'd0);
        release_out("th14");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/popcount_sequencer.md
POPCOUNT_SEQUENCER -- requirements
Module: popcount_sequencer

Interface
REQ-001 Parameter NBYTES, default 4, SHALL be the number of bytes per input word (legal range 1..16).
REQ-002 Localparam CW SHALL equal $clog2(8*NBYTES+1) (CW=6 for NBYTES=4).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 x  input  8*NBYTES  SHALL be the word whose set bits are counted.
REQ-006 in_valid  input  1  SHALL indicate x is valid.
REQ-007 in_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-008 y  output  CW  SHALL carry the count of set bits in the accepted word.
REQ-009 out_valid  output  1  SHALL indicate y is valid.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes y this cycle.

Function
REQ-011 The block SHALL time-share one 8-bit popcount unit, processing one byte per cycle.
REQ-012 FSM states SHALL be IDLE, COUNT, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-014 IDLE with in_valid=1: capture x into a shift register, clear accumulator, clear byte index, go to COUNT.
REQ-015 IDLE with in_valid=0: remain in IDLE; accumulator and y unchanged.
REQ-016 Each COUNT cycle SHALL add popcount(shreg[7:0]) to the accumulator, shift shreg right 8 bits, increment the index.
REQ-017 Bytes SHALL be processed LSB byte first; order does not affect the result.
REQ-018 After exactly NBYTES COUNT cycles the FSM SHALL enter DONE; word accepted at edge k gives out_valid=1 after edge k+NBYTES.
REQ-019 Accumulator SHALL be CW bits and never overflow (max 8*NBYTES fits CW).
REQ-020 y SHALL equal the accumulator and be stable while out_valid=1.
REQ-021 DONE with out_ready=0: hold y and out_valid indefinitely.
REQ-022 DONE with out_ready=1: go to IDLE; in_ready=1 the following cycle (no same-cycle accept in DONE).
REQ-023 in_valid and x SHALL be ignored outside IDLE; x changes during COUNT SHALL NOT affect the result.
REQ-024 Throughput SHALL be one word per NBYTES+2 cycles with out_ready tied 1.

Reset
REQ-025 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, y=0, accumulator=0, index=0, shreg=0, immediately and asynchronously.
REQ-026 rst asserted mid-COUNT or in DONE SHALL discard the word in progress; no out_valid SHALL follow for it.

Configuration
REQ-027 Macro POPCOUNT_SEQUENCER_THRESH_EN SHALL add input thresh (CW bits) and output over (1 bit).
REQ-028 With the macro: over SHALL equal (y >= thresh) while out_valid=1, 0 otherwise; thresh sampled in the IDLE accept cycle; over reset value 0.
REQ-029 Without the macro: neither port SHALL exist and all other behaviour SHALL be identical.

Structure
REQ-030 A shared package popcount_pkg SHALL hold the FSM state enum (IDLE, COUNT, DONE) and the count-width function.
REQ-031 Sub-module popcount8 (8-bit in, 4-bit out, purely combinational full-adder tree) SHALL be instantiated exactly once.

Verification
REQ-032 NBYTES=4, x=0x00000000 accepted -> out_valid after 4 COUNT cycles, y=0.
REQ-033 x=0xFFFFFFFF -> y=32 (no overflow), out_valid 4 cycles after accept.
REQ-034 x=0xA5A50F01 -> y=13; x toggled to 0xFFFFFFFF during COUNT -> y still 13.
REQ-035 out_ready=0 for 10 cycles in DONE -> y and out_valid held, in_ready=0; new in_valid ignored.
REQ-036 rst pulse during second COUNT cycle -> immediate IDLE, y=0, out_valid never asserted for that word.
REQ-037 With POPCOUNT_SEQUENCER_THRESH_EN, thresh=13, x=0xA5A50F01 -> over=1; thresh=14 -> over=0.
